// File: rtl/fetch_queue_unit_if.sv
// Fetch queue bus: decode-side head handshake, ROM address/data, fetch control
// and redirect request, bundled for fetch_queue_unit.
//   fetch_en        fetch permission (0 freezes PC, blocks pushes)
//   redirect_valid  flush-and-redirect request
//   redirect_pc     new PC when redirect_valid=1
//   rom_addr        current PC presented to the instruction ROM
//   rom_data        combinational ROM word for rom_addr
//   out_valid       queue head valid
//   out_ready       decode accepts head this cycle
//   out_pc          PC of head entry
//   out_instr       instruction of head entry
//   queue_count     current occupancy
interface fetch_queue_unit_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 32,
  parameter int QUEUE_DEPTH = 4
);
  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic                   fetch_en;
  logic                   redirect_valid;
  logic [PC_WIDTH-1:0]    redirect_pc;
  logic [PC_WIDTH-1:0]    rom_addr;
  logic [INSTR_WIDTH-1:0] rom_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [PC_WIDTH-1:0]    out_pc;
  logic [INSTR_WIDTH-1:0] out_instr;
  logic [CNT_W-1:0]       queue_count;

  // Fetch unit side
  modport master (
    input  fetch_en, redirect_valid, redirect_pc, rom_data, out_ready,
    output rom_addr, out_valid, out_pc, out_instr, queue_count
  );

  // Environment side (decode, ROM, branch/exception source)
  modport slave (
    output fetch_en, redirect_valid, redirect_pc, rom_data, out_ready,
    input  rom_addr, out_valid, out_pc, out_instr, queue_count
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Fetch stage with instruction queue. Owns the PC, addresses a combinational
// ROM, and buffers {pc, instruction} pairs in a QUEUE_DEPTH-entry FIFO whose
// head is offered to decode through a valid/ready handshake. Supports fetch
// enable, backpressure and a redirect that flushes the queue and reloads the PC.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    fetch_queue_unit_if.master (ROM, control, decode handshake)
module fetch_queue_unit #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter int RESET_PC    = 0,
  parameter int PC_STEP     = 1
) (
  input  logic clk,
  input  logic reset,
  fetch_queue_unit_if.master bus
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PC_WIDTH-1:0]    pc_mem_q    [QUEUE_DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem_q [QUEUE_DEPTH];

  logic pop;
  logic space;
  logic push;

  // A same-cycle pop frees a slot, so a full queue can accept a push while
  // draining. Redirect suppresses push; it also overrides pop below.
  assign pop   = (count_q != '0) & bus.out_ready;
  assign space = (count_q < CNT_W'(QUEUE_DEPTH)) | pop;
  assign push  = bus.fetch_en & ~bus.redirect_valid & space;

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.redirect_valid) begin
      pc_d     = bus.redirect_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + PC_WIDTH'(PC_STEP);
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= PC_WIDTH'(RESET_PC);
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared only by reset; a redirect just rewinds the pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]    <= pc_q;
      instr_mem_q[wr_ptr_q] <= bus.rom_data;
    end
  end

  assign bus.rom_addr    = pc_q;
  assign bus.out_valid   = (count_q != '0);
  assign bus.out_pc      = pc_mem_q[rd_ptr_q];
  assign bus.out_instr   = instr_mem_q[rd_ptr_q];
  assign bus.queue_count = count_q;

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised next-generation fetch stage: owns the program counter and drives a combinational instruction ROM.
- Buffers fetched {pc, instruction} pairs in a QUEUE_DEPTH-entry FIFO.
- Presents the FIFO head to decode through a valid/ready handshake.
- Adds what the single-cycle fetcher lacks: backpressure stall, fetch enable, and a redirect that flushes the queue and reloads the PC.

Parameters:
- PC_WIDTH, 8, width of the PC and ROM address.
- INSTR_WIDTH, 32, instruction width.
- QUEUE_DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 1, PC increment per fetched instruction (ROM is word-addressed).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_en  in  1  permits fetching; 0 freezes the PC and blocks pushes.
- redirect_valid  in  1  flush-and-redirect request (branch or exception).
- redirect_pc  in  PC_WIDTH  new PC used when redirect_valid=1.
- rom_addr  out  PC_WIDTH  equals the current PC register.
- rom_data  in  INSTR_WIDTH  combinational ROM output for rom_addr, same cycle.
- out_valid  out  1  queue not empty.
- out_ready  in  1  decode accepts the head this cycle.
- out_pc  out  PC_WIDTH  PC of the head entry.
- out_instr  out  INSTR_WIDTH  instruction of the head entry.
- queue_count  out  clog2(QUEUE_DEPTH)+1  current occupancy.

Behaviour:
- Reset, asynchronous on reset=1:
  - pc=RESET_PC, so rom_addr=RESET_PC.
  - Read/write pointers=0, count=0, all queue storage=0.
  - out_valid=0, out_pc=0, out_instr=0, queue_count=0.
- Signals per cycle:
  - pop = out_valid & out_ready.
  - space = (count < QUEUE_DEPTH) | pop. A pop in the same cycle frees a slot, so push and pop are allowed together when full.
  - push = fetch_en & ~redirect_valid & space.
- On push:
  - Write {pc, rom_data} at the write pointer.
  - pc <= pc + PC_STEP, modulo 2^PC_WIDTH; wrap from max to 0 is silent.
- No push: pc holds.
- count update:
  - push only: count+1.
  - pop only: count-1.
  - both or neither: unchanged.
- Pointers wrap modulo QUEUE_DEPTH.
- Head outputs:
  - out_pc and out_instr come combinationally from the read-pointer entry.
  - out_valid = (count != 0).
  - Outputs must stay stable while out_valid=1 and out_ready=0.
- Latency: an instruction at rom_addr in cycle N is visible at the head in cycle N+1 if the queue was empty. There is no bypass from rom_data to out_instr.
- Redirect has priority over everything:
  - pc <= redirect_pc.
  - count, read and write pointers <= 0.
  - No push that cycle.
  - A pop asserted in the same cycle is ignored; decode must also discard on redirect.
  - out_valid=0 in cycle N+1.
  - Fetch from redirect_pc occurs in cycle N+1, visible at the head in N+2.
  - Storage contents need not be cleared.
- Full (count=QUEUE_DEPTH) with no pop: push is blocked, pc holds, and rom_addr is re-presented until space exists.
- Empty with out_ready=1: no pop; count stays 0 and never underflows.
- fetch_en=0: no pushes, while draining by pop continues. A redirect while fetch_en=0 still loads pc and flushes.
- Reset mid-operation: immediate return to reset values regardless of any handshake in progress. In-flight entries are lost.
- Sizing: all arithmetic is unsigned, and queue_count must represent QUEUE_DEPTH exactly.

Test Plan:
- Reset sequencing: reset high 3 cycles, then low with fetch_en=1 and out_ready=1, ROM word i = 0xA000_0000+i.
  - Required: rom_addr=0 during reset; out_valid rises one cycle after release with out_pc=0, out_instr=0xA0000000.
  - Then one instruction per cycle with consecutive PCs.
- Backpressure: out_ready=0 with fetch_en=1.
  - Required: queue_count climbs 1,2,3,4; rom_addr then holds at 4 and out_pc holds at 0.
  - Raise out_ready for 1 cycle: entry pc=0 popped, entry pc=4 pushed in the same cycle, count stays 4.
- Redirect: with count=3, assert redirect_valid=1 and redirect_pc=0x40 for 1 cycle while out_ready=1.
  - Required: next cycle out_valid=0, queue_count=0, rom_addr=0x40.
  - The cycle after: out_valid=1 with out_pc=0x40.
- PC wrap: redirect_pc=0xFE with PC_WIDTH=8.
  - Required: fetched PCs are 0xFE, 0xFF, 0x00, 0x01 in order, with the correct ROM data for each.
- fetch_en gating: fetch_en=0 with count=2 and out_ready=1.
  - Required: two pops, then out_valid=0; rom_addr is unchanged throughout.
- Async reset mid-stream: assert reset asynchronously between clock edges while count=3.
  - Required: out_valid, queue_count and rom_addr go to 0 and RESET_PC immediately, before the next clk edge.
